// File: rtl/digit_entry_ctrl_pkg.sv
// Shared definitions for the digit entry controller.
//   DIG0..DIG3  : one-hot cursor codes (MSB is the leftmost digit d0)
//   MAX_DIGIT   : largest legal decimal digit value
//   act_e       : the single action applied per cycle, in priority order
//   helpers     : cursor decode, one-hot check and button priority pick
package digit_entry_ctrl_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] DIG0 = 4'b1000;
    localparam logic [3:0] DIG1 = 4'b0100;
    localparam logic [3:0] DIG2 = 4'b0010;
    localparam logic [3:0] DIG3 = 4'b0001;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_RIGHT = 3'd3,
        ACT_LEFT  = 3'd4
    } act_e;

    function automatic logic [1:0] cursor_to_idx(input logic [3:0] cursor);
        case (cursor)
            DIG1:    return 2'd1;
            DIG2:    return 2'd2;
            DIG3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic cursor_legal(input logic [3:0] cursor);
        return (cursor == DIG0) || (cursor == DIG1) ||
               (cursor == DIG2) || (cursor == DIG3);
    endfunction

    // Only the highest-priority press survives; the rest are dropped.
    function automatic act_e pick_action(input logic up, input logic down,
                                         input logic right, input logic left);
        if (up)    return ACT_UP;
        if (down)  return ACT_DOWN;
        if (right) return ACT_RIGHT;
        if (left)  return ACT_LEFT;
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Button inputs and display-driver outputs of the digit entry controller.
//   btn_up/down/left/right : raw asynchronous push-buttons, active-high
//   number                 : value of the digit under the cursor
//   currLED                : one-hot cursor
//   digits                 : {d0,d1,d2,d3}, d0 in the top nibble
//   changed                : one-cycle pulse when a digit value changes
// master: button source / display consumer.  slave: the controller.
interface digit_entry_ctrl_if;
    import digit_entry_ctrl_pkg::*;

    logic                          btn_up;
    logic                          btn_down;
    logic                          btn_left;
    logic                          btn_right;
    logic [DIGIT_W-1:0]            number;
    logic [3:0]                    currLED;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic                          changed;

    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        input  number, currLED, digits, changed
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        output number, currLED, digits, changed
    );

endinterface

// File: rtl/digit_entry_ctrl_button_debounce.sv
// Per-button conditioning: two-flop synchroniser, counter debounce and
// rising-edge detection of the accepted level.
//   clk         : system clock
//   rst         : synchronous active-low reset
//   raw         : raw asynchronous button level
//   press_pulse : registered one-cycle pulse on each accepted 0->1 transition
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1600000,
    parameter int CNT_BITS        = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press_pulse
);

    logic                sync1_reg;
    logic                sync2_reg;
    logic                level_reg;
    logic                level_prev_reg;
    logic                pulse_reg;
    logic [CNT_BITS-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            level_reg      <= 1'b0;
            level_prev_reg <= 1'b0;
            pulse_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            sync1_reg      <= raw;
            sync2_reg      <= sync1_reg;
            level_prev_reg <= level_reg;
            // Registered so the top-level update sees a clean, glitch-free pulse.
            pulse_reg      <= level_reg & ~level_prev_reg;

            // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle
            // that the synced input disagrees with the accepted level.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_BITS'(1);
            end
        end
    end

    assign press_pulse = pulse_reg;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Turns four push-buttons into an edited 4-digit decimal value for the
// seven-segment display driver.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : slave side of digit_entry_ctrl_if (buttons in, display values out)
// Up/down edit the digit under the cursor modulo 10; left/right rotate the
// one-hot cursor. All outputs come straight from registers.
module digit_entry_ctrl
    import digit_entry_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1600000,
    parameter int CNT_BITS        = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_entry_ctrl_if.slave    bus
);

    // Button order: 0=up, 1=down, 2=right, 3=left
    logic [3:0] raw_btn;
    logic [3:0] press;

    assign raw_btn = {bus.btn_left, bus.btn_right, bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_BITS       (CNT_BITS)
            ) u_debounce (
                .clk        (clk),
                .rst        (rst),
                .raw        (raw_btn[gi]),
                .press_pulse(press[gi])
            );
        end
    endgenerate

    logic [DIGIT_W-1:0] digit_reg  [NUM_DIGITS];
    logic [DIGIT_W-1:0] digit_next [NUM_DIGITS];
    logic [3:0]         cursor_reg;
    logic [3:0]         cursor_next;
    logic [DIGIT_W-1:0] number_reg;
    logic [DIGIT_W-1:0] number_next;
    logic               changed_reg;
    logic               changed_next;

    act_e               act;
    logic [1:0]         sel;
    logic [DIGIT_W-1:0] cur_val;
    logic [DIGIT_W-1:0] new_val;

    always_comb begin
        digit_next   = digit_reg;
        cursor_next  = cursor_reg;
        number_next  = number_reg;
        changed_next = 1'b0;
        act          = pick_action(press[0], press[1], press[2], press[3]);
        sel          = cursor_to_idx(cursor_reg);
        cur_val      = digit_reg[sel];
        new_val      = cur_val;

        if (!cursor_legal(cursor_reg)) begin
            // Corrupted cursor: snap back to the leftmost digit, drop any action.
            cursor_next = DIG0;
            number_next = digit_reg[0];
        end else begin
            case (act)
                ACT_UP: begin
                    new_val         = (cur_val >= MAX_DIGIT) ? '0 : cur_val + 4'd1;
                    digit_next[sel] = new_val;
                    number_next     = new_val;
                    changed_next    = 1'b1;
                end
                ACT_DOWN: begin
                    new_val         = (cur_val == '0) ? MAX_DIGIT : cur_val - 4'd1;
                    digit_next[sel] = new_val;
                    number_next     = new_val;
                    changed_next    = 1'b1;
                end
                ACT_RIGHT: begin
                    cursor_next = {cursor_reg[0], cursor_reg[3:1]};
                    number_next = digit_reg[cursor_to_idx(cursor_next)];
                end
                ACT_LEFT: begin
                    cursor_next = {cursor_reg[2:0], cursor_reg[3]};
                    number_next = digit_reg[cursor_to_idx(cursor_next)];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
            cursor_reg  <= DIG0;
            number_reg  <= '0;
            changed_reg <= 1'b0;
        end else begin
            digit_reg   <= digit_next;
            cursor_reg  <= cursor_next;
            number_reg  <= number_next;
            changed_reg <= changed_next;
        end
    end

    assign bus.number  = number_reg;
    assign bus.currLED = cursor_reg;
    assign bus.digits  = {digit_reg[0], digit_reg[1], digit_reg[2], digit_reg[3]};
    assign bus.changed = changed_reg;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
module tb_digit_entry_ctrl;

    localparam int DC  = 4;
    localparam int GAP = 12;

    logic clk;
    logic rst;

    digit_entry_ctrl_if bus ();

    digit_entry_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_BITS       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: digit values, cursor position, expected pulse count
    int d [4];
    int cur;
    int exp_chg;

    // Observed changed pulses
    int chg_cnt    = 0;
    int chg_run    = 0;
    int chg_maxrun = 0;

    always @(negedge clk) begin
        if (bus.changed === 1'b1) begin
            chg_cnt++;
            chg_run++;
            if (chg_run > chg_maxrun) chg_maxrun = chg_run;
        end else begin
            chg_run = 0;
        end
    end

    function automatic logic [3:0] exp_led();
        return 4'b1000 >> cur;
    endfunction

    function automatic logic [15:0] exp_digits();
        return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    endfunction

    // Model of one accepted press: 0=up, 1=down, 2=right, 3=left
    task automatic model_action(input int b);
        case (b)
            0: begin d[cur] = (d[cur] + 1) % 10; exp_chg++; end
            1: begin d[cur] = (d[cur] + 9) % 10; exp_chg++; end
            2: cur = (cur + 1) % 4;
            default: cur = (cur + 3) % 4;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) d[i] = 0;
        cur = 0;
    endtask

    task automatic set_btns(input logic [3:0] v);  // {left,right,down,up}
        bus.btn_up    = v[0];
        bus.btn_down  = v[1];
        bus.btn_right = v[2];
        bus.btn_left  = v[3];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a button pattern for 'hold' cycles, then release and let it settle
    task automatic press(input logic [3:0] v, input int hold);
        @(negedge clk);
        set_btns(v);
        idle(hold);
        set_btns(4'b0000);
        idle(GAP);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_btns(4'b0000);
        idle(3);
        model_reset();
        n_checks++; if (bus.number !== 4'd0) begin n_fail++; $display("FAIL reset_number got=%h exp=0", bus.number); end
        n_checks++; if (bus.currLED !== 4'b1000) begin n_fail++; $display("FAIL reset_currLED got=%b exp=1000", bus.currLED); end
        n_checks++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got=%h exp=0000", bus.digits); end
        n_checks++; if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got=%b exp=0", bus.changed); end
        rst = 1'b1;
        idle(2);
        $display("reset: number=%h currLED=%b digits=%h", bus.number, bus.currLED, bus.digits);
    endtask

    // First up press checked edge-by-edge, then two more
    task automatic test_up3();
        int base;
        base = chg_cnt;
        @(negedge clk);
        set_btns(4'b0001);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.changed !== (k == 7)) begin
                n_fail++; $display("FAIL latency_changed edge=%0d got=%b exp=%b", k, bus.changed, (k == 7));
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (bus.number !== ((k == 7) ? 4'd1 : 4'd0)) begin
                    n_fail++; $display("FAIL latency_number edge=%0d got=%h exp=%0d", k, bus.number, (k == 7) ? 1 : 0);
                end
            end
        end
        idle(1);
        set_btns(4'b0000);
        idle(GAP);
        model_action(0);
        press(4'b0001, 10);
        model_action(0);
        press(4'b0001, 10);
        model_action(0);
        n_checks++; if (bus.number !== 4'd3) begin n_fail++; $display("FAIL up3_number got=%h exp=3", bus.number); end
        n_checks++; if (bus.digits !== 16'h3000) begin n_fail++; $display("FAIL up3_digits got=%h exp=3000", bus.digits); end
        n_checks++; if (chg_cnt - base !== 3) begin n_fail++; $display("FAIL up3_pulses got=%0d exp=3", chg_cnt - base); end
        n_checks++; if (chg_maxrun !== 1) begin n_fail++; $display("FAIL up3_width got=%0d exp=1", chg_maxrun); end
        $display("up3: number=%h digits=%h pulses=%0d", bus.number, bus.digits, chg_cnt - base);
    endtask

    task automatic test_wrap();
        int base;
        while (d[cur] != 9) begin
            press(4'b0001, 6);
            model_action(0);
        end
        n_checks++; if (bus.number !== 4'd9) begin n_fail++; $display("FAIL wrap_pre got=%h exp=9", bus.number); end
        base = chg_cnt;
        press(4'b0001, 6);
        model_action(0);
        n_checks++; if (bus.number !== 4'd0) begin n_fail++; $display("FAIL wrap_up got=%h exp=0", bus.number); end
        n_checks++; if (chg_cnt - base !== 1) begin n_fail++; $display("FAIL wrap_up_changed got=%0d exp=1", chg_cnt - base); end
        press(4'b0010, 6);
        model_action(1);
        n_checks++; if (bus.number !== 4'd9) begin n_fail++; $display("FAIL wrap_down got=%h exp=9", bus.number); end
        n_checks++; if (bus.digits !== exp_digits()) begin n_fail++; $display("FAIL wrap_digits got=%h exp=%h", bus.digits, exp_digits()); end
        $display("wrap: number=%h digits=%h", bus.number, bus.digits);
    endtask

    task automatic test_cursor();
        int base;
        logic [3:0] seq [4];
        seq[0] = 4'b0100; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b1000;
        base = chg_cnt;
        for (int i = 0; i < 4; i++) begin
            press(4'b0100, 6);
            model_action(2);
            n_checks++;
            if (bus.currLED !== seq[i]) begin n_fail++; $display("FAIL right_%0d got=%b exp=%b", i, bus.currLED, seq[i]); end
            n_checks++;
            if (bus.number !== 4'(d[cur])) begin n_fail++; $display("FAIL right_number_%0d got=%h exp=%0d", i, bus.number, d[cur]); end
            $display("right %0d: currLED=%b number=%h", i, bus.currLED, bus.number);
            if (i == 2) begin
                // Give d3 a distinctive value before leaving it
                press(4'b0001, 6); model_action(0);
                press(4'b0001, 6); model_action(0);
                base = base + 2;
            end
        end
        press(4'b1000, 6);
        model_action(3);
        n_checks++; if (bus.currLED !== 4'b0001) begin n_fail++; $display("FAIL left got=%b exp=0001", bus.currLED); end
        n_checks++; if (bus.number !== 4'(d[3])) begin n_fail++; $display("FAIL left_number got=%h exp=%0d", bus.number, d[3]); end
        n_checks++; if (chg_cnt - base !== 0) begin n_fail++; $display("FAIL cursor_changed got=%0d exp=0", chg_cnt - base); end
        $display("left: currLED=%b number=%h", bus.currLED, bus.number);
    endtask

    task automatic test_glitch();
        int base;
        logic [3:0] led0, num0;
        logic [15:0] dig0;
        base = chg_cnt; led0 = bus.currLED; num0 = bus.number; dig0 = bus.digits;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_btns(4'b0001 << $urandom_range(0, 3));
            idle($urandom_range(1, DC - 1));
            set_btns(4'b0000);
            idle($urandom_range(1, 6));
        end
        for (int i = 0; i < 5; i++) begin  // bounce train 1-0-1-0-1
            @(negedge clk);
            set_btns((i % 2 == 0) ? 4'b0001 : 4'b0000);
        end
        @(negedge clk);
        set_btns(4'b0000);
        idle(GAP);
        n_checks++; if (bus.number !== num0) begin n_fail++; $display("FAIL glitch_number got=%h exp=%h", bus.number, num0); end
        n_checks++; if (bus.currLED !== led0) begin n_fail++; $display("FAIL glitch_currLED got=%b exp=%b", bus.currLED, led0); end
        n_checks++; if (bus.digits !== dig0) begin n_fail++; $display("FAIL glitch_digits got=%h exp=%h", bus.digits, dig0); end
        n_checks++; if (chg_cnt - base !== 0) begin n_fail++; $display("FAIL glitch_changed got=%0d exp=0", chg_cnt - base); end
        $display("glitch: number=%h currLED=%b changed_pulses=%0d", bus.number, bus.currLED, chg_cnt - base);
    endtask

    task automatic test_simultaneous();
        press(4'b0101, 7);  // up + right together: up wins
        model_action(0);
        n_checks++; if (bus.number !== 4'(d[cur])) begin n_fail++; $display("FAIL simul_number got=%h exp=%0d", bus.number, d[cur]); end
        n_checks++; if (bus.currLED !== exp_led()) begin n_fail++; $display("FAIL simul_currLED got=%b exp=%b", bus.currLED, exp_led()); end
        n_checks++; if (chg_cnt !== exp_chg) begin n_fail++; $display("FAIL simul_changed got=%0d exp=%0d", chg_cnt, exp_chg); end
        $display("simultaneous: number=%h currLED=%b", bus.number, bus.currLED);
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 16; i++) begin
            b = $urandom_range(0, 3);
            press(4'b0001 << b, $urandom_range(DC + 1, 12));
            model_action(b);
            n_checks++; if (bus.number !== 4'(d[cur])) begin n_fail++; $display("FAIL rand_number_%0d got=%h exp=%0d", i, bus.number, d[cur]); end
            n_checks++; if (bus.currLED !== exp_led()) begin n_fail++; $display("FAIL rand_currLED_%0d got=%b exp=%b", i, bus.currLED, exp_led()); end
            n_checks++; if (bus.digits !== exp_digits()) begin n_fail++; $display("FAIL rand_digits_%0d got=%h exp=%h", i, bus.digits, exp_digits()); end
            n_checks++; if (chg_cnt !== exp_chg) begin n_fail++; $display("FAIL rand_changed_%0d got=%0d exp=%0d", i, chg_cnt, exp_chg); end
            $display("random %0d: btn=%0d number=%h currLED=%b digits=%h", i, b, bus.number, bus.currLED, bus.digits);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_btns(4'b0001);
        idle(9);
        model_action(0);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        n_checks++; if (bus.number !== 4'd0) begin n_fail++; $display("FAIL mid_rst_number got=%h exp=0", bus.number); end
        n_checks++; if (bus.currLED !== 4'b1000) begin n_fail++; $display("FAIL mid_rst_currLED got=%b exp=1000", bus.currLED); end
        n_checks++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_digits got=%h exp=0000", bus.digits); end
        n_checks++; if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL mid_rst_changed got=%b exp=0", bus.changed); end
        rst = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.changed !== (k == 7)) begin
                n_fail++; $display("FAIL mid_rst_latency edge=%0d got=%b exp=%b", k, bus.changed, (k == 7));
            end
        end
        model_action(0);
        n_checks++; if (bus.number !== 4'd1) begin n_fail++; $display("FAIL mid_rst_after got=%h exp=1", bus.number); end
        n_checks++; if (bus.digits !== 16'h1000) begin n_fail++; $display("FAIL mid_rst_digits_after got=%h exp=1000", bus.digits); end
        idle(20);  // still held: must not repeat
        set_btns(4'b0000);
        idle(GAP);
        n_checks++; if (chg_cnt !== exp_chg) begin n_fail++; $display("FAIL no_repeat got=%0d exp=%0d", chg_cnt, exp_chg); end
        n_checks++; if (bus.number !== 4'(d[cur])) begin n_fail++; $display("FAIL no_repeat_number got=%h exp=%0d", bus.number, d[cur]); end
        $display("reset mid-press: number=%h digits=%h pulses=%0d", bus.number, bus.digits, chg_cnt);
    endtask

    initial begin
        exp_chg = 0;
        model_reset();
        test_reset();
        test_up3();
        test_wrap();
        test_cursor();
        test_glitch();
        test_simultaneous();
        test_random();
        test_reset_mid();
        n_checks++; if (chg_maxrun !== 1) begin n_fail++; $display("FAIL changed_width got=%0d exp=1", chg_maxrun); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
